tdm_demux_1to4: RTL and testbench
=================================

Name: tdm_demux_1to4

Overview:
- Sequential 1-to-4 time-division demultiplexer; the receive-side counterpart of the 4:1 selector datapath.
- Accepts one beat per valid cycle from a single input stream and distributes beats round-robin to four registered channel outputs (ch0..ch3), aligned by a frame-sync marker.
- Sits after a serialised/multiplexed link; each beat is delivered with a one-cycle per-channel valid strobe.

Parameters:
- WIDTH, 8, data width of input and each channel output
- HOLD, 1, 1 = unwritten channel outputs keep last value; 0 = a channel output clears to 0 in every cycle its strobe is low

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- din  input  WIDTH  multiplexed data beat
- din_valid  input  1  beat present this cycle
- frame_sync  input  1  marks the current beat (or the next beat, if din_valid=0) as channel 0
- out0, out1, out2, out3  output  WIDTH  registered channel data
- out_valid  output  4  one-hot strobe; bit k high for the cycle in which outk carries a new beat
- ch  output  2  channel the next beat will be routed to
- locked  output  1  high in SYNC state
- frame_done  output  1  one-cycle pulse in the same cycle as out_valid[3]
- sync_err  output  1  one-cycle pulse on misaligned frame_sync

Behaviour:
- Reset (rst_n=0, asynchronous): out0..3=0, out_valid=0, ch=0, locked=0, frame_done=0, sync_err=0, state=UNSYNC. Release is sampled on the next clk edge.
- FSM states:
  - UNSYNC:
    - din_valid & !frame_sync: beat dropped, no strobe.
    - din_valid & frame_sync: beat routed to ch0; ch<=1; go SYNC.
    - frame_sync & !din_valid: ch<=0; go SYNC.
  - SYNC:
    - Each din_valid beat goes to out[ch], then ch<=ch+1 mod 4 (3 wraps to 0).
    - frame_sync with ch==0 is accepted silently.
    - frame_sync with ch!=0: the beat (if any) is forced to ch0, ch<=1 (or 0 if !din_valid), sync_err pulses; state stays SYNC.
- Latency: beat sampled at edge N appears on outk with out_valid[k]=1 after edge N (visible cycle N+1). Throughput 1 beat/cycle.
- din_valid=0: no strobe; ch unchanged except on frame_sync.
- HOLD=0: outk=0 in any cycle out_valid[k]=0.
- frame_done asserts with out_valid[3], including when channel 3 was selected manually.
- locked = (state==SYNC). sync_err is registered, same latency as strobes.
- Reset mid-frame: all outputs clear immediately; partial frame discarded; relock requires a new frame_sync.

Optional Feature:
- Macro: DEMUX_MANUAL_SEL_EN
- Defined:
  - Adds inputs man_sel (1) and s1, s0 (1 each).
  - While man_sel=1, each valid beat routes to channel {s1,s0} regardless of state.
  - ch, state and frame_sync handling are frozen; sync_err is suppressed.
  - On man_sel falling, round-robin resumes from the frozen ch.
- Undefined: ports absent; pure round-robin behaviour as above.

Test Plan:
- Reset, then frame_sync+din_valid with din=0x11,0x22,0x33,0x44 on 4 consecutive cycles -> out0..3=0x11..0x44; out_valid=0001,0010,0100,1000 one cycle after each; frame_done with the last; locked=1.
- Beats 0xAA,0xBB with no frame_sync after reset -> no strobes, outputs stay 0, locked=0; then frame_sync+0xCC -> out0=0xCC.
- Locked, 2 beats sent (ch=2), then frame_sync+0x55 -> sync_err pulse, out0=0x55, out_valid=0001, ch=1.
- Locked, 9 beats 0x01..0x09 with din_valid gaps every other cycle -> channel sequence 0,1,2,3,0,1,2,3,0; ch wraps 3->0; no strobes in gap cycles.
- rst_n low asynchronously mid-frame (between edges) -> all outputs 0 before next edge; beats after release dropped until frame_sync; HOLD=0 run: out1=0 whenever out_valid[1]=0.
- DEMUX_MANUAL_SEL_EN: man_sel=1, s1s0=10, din=0x7E -> out2=0x7E, out_valid=0100, ch unchanged; man_sel=0 -> next beat to frozen ch.

Source files
------------

// File: rtl/tdm_demux_1to4_if.sv
// Bus bundle for tdm_demux_1to4: multiplexed input beat side plus the four
// registered channel outputs and their status strobes.
interface tdm_demux_1to4_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             frame_sync;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [3:0]       out_valid;
  logic [1:0]       ch;
  logic             locked;
  logic             frame_done;
  logic             sync_err;

  modport master (
    output din, din_valid, frame_sync,
    input  out0, out1, out2, out3, out_valid, ch, locked, frame_done, sync_err
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output out0, out1, out2, out3, out_valid, ch, locked, frame_done, sync_err
  );
endinterface

// File: rtl/tdm_demux_1to4.sv
// Round-robin 1:4 TDM demultiplexer aligned by frame_sync.
// Optional DEMUX_MANUAL_SEL_EN adds man_sel/s1/s0 for forced channel routing.
module tdm_demux_1to4 #(
  parameter int WIDTH = 8,
  parameter bit HOLD  = 1'b1
) (
  input logic clk,
  input logic rst_n,
`ifdef DEMUX_MANUAL_SEL_EN
  input logic man_sel,
  input logic s1,
  input logic s0,
`endif
  tdm_demux_1to4_if.slave bus
);

  typedef enum logic {UNSYNC, SYNC} state_t;

  state_t           state;
  logic [1:0]       ch_q;
  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       valid_q;
  logic             done_q;
  logic             err_q;

  logic             wr;
  logic [1:0]       tgt;
  logic [1:0]       ch_nxt;
  state_t           state_nxt;
  logic             err_nxt;

  always_comb begin
    wr        = 1'b0;
    tgt       = ch_q;
    ch_nxt    = ch_q;
    state_nxt = state;
    err_nxt   = 1'b0;
    // frame_sync realigns to ch0 in both states; only a misaligned one while locked is an error
    if (bus.frame_sync) begin
      state_nxt = SYNC;
      tgt       = 2'd0;
      wr        = bus.din_valid;
      ch_nxt    = bus.din_valid ? 2'd1 : 2'd0;
      err_nxt   = (state == SYNC) && (ch_q != 2'd0);
    end else if (bus.din_valid && state == SYNC) begin
      wr     = 1'b1;
      ch_nxt = ch_q + 2'd1;
    end
`ifdef DEMUX_MANUAL_SEL_EN
    if (man_sel) begin
      wr        = bus.din_valid;
      tgt       = {s1, s0};
      ch_nxt    = ch_q;
      state_nxt = state;
      err_nxt   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= UNSYNC;
      ch_q    <= '0;
      valid_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) data_q[k] <= '0;
    end else begin
      state  <= state_nxt;
      ch_q   <= ch_nxt;
      err_q  <= err_nxt;
      done_q <= wr && (tgt == 2'd3);
      for (int unsigned k = 0; k < 4; k++) begin
        if (wr && tgt == 2'(k)) begin
          data_q[k]  <= bus.din;
          valid_q[k] <= 1'b1;
        end else begin
          valid_q[k] <= 1'b0;
          if (!HOLD) data_q[k] <= '0;
        end
      end
    end
  end

  assign bus.out0       = data_q[0];
  assign bus.out1       = data_q[1];
  assign bus.out2       = data_q[2];
  assign bus.out3       = data_q[3];
  assign bus.out_valid  = valid_q;
  assign bus.ch         = ch_q;
  assign bus.locked     = (state == SYNC);
  assign bus.frame_done = done_q;
  assign bus.sync_err   = err_q;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Randomized + directed bench for tdm_demux_1to4; HOLD=1 and HOLD=0 instances
// share one stimulus stream and are checked against a frame-level model.
module tb_tdm_demux_1to4;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;
  logic             frame_sync = 1'b0;
`ifdef DEMUX_MANUAL_SEL_EN
  logic             man_sel = 1'b0;
  logic             s1 = 1'b0;
  logic             s0 = 1'b0;
`endif

  always #5 clk = ~clk;

  tdm_demux_1to4_if #(.WIDTH(WIDTH)) bh ();
  tdm_demux_1to4_if #(.WIDTH(WIDTH)) bc ();

  assign bh.din = din;  assign bh.din_valid = din_valid;  assign bh.frame_sync = frame_sync;
  assign bc.din = din;  assign bc.din_valid = din_valid;  assign bc.frame_sync = frame_sync;

  tdm_demux_1to4 #(.WIDTH(WIDTH), .HOLD(1'b1)) u_hold (
    .clk(clk), .rst_n(rst_n),
`ifdef DEMUX_MANUAL_SEL_EN
    .man_sel(man_sel), .s1(s1), .s0(s0),
`endif
    .bus(bh.slave)
  );

  tdm_demux_1to4 #(.WIDTH(WIDTH), .HOLD(1'b0)) u_clr (
    .clk(clk), .rst_n(rst_n),
`ifdef DEMUX_MANUAL_SEL_EN
    .man_sel(man_sel), .s1(s1), .s0(s0),
`endif
    .bus(bc.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: which channel is next, whether a frame marker has been seen,
  // and what each channel output should show under each HOLD policy.
  int               m_next;
  bit               m_locked;
  logic [WIDTH-1:0] m_hold [4];
  logic [WIDTH-1:0] m_clr  [4];
  logic [3:0]       m_valid;
  bit               m_done;
  bit               m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_next = 0; m_locked = 0; m_valid = '0; m_done = 0; m_err = 0;
    for (int i = 0; i < 4; i++) begin m_hold[i] = '0; m_clr[i] = '0; end
  endtask

  task automatic model_step(input bit dv, input bit fs, input logic [WIDTH-1:0] d,
                            input bit man, input int msel);
    int dest;
    dest = -1;
    m_err = 0;
    if (man) begin
      if (dv) dest = msel;
    end else if (fs) begin
      if (m_locked && m_next != 0) m_err = 1;
      m_locked = 1;
      if (dv) dest = 0;
      m_next = dv ? 1 : 0;
    end else if (dv && m_locked) begin
      dest = m_next;
      m_next = (m_next + 1) % 4;
    end
    m_valid = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == dest) begin
        m_hold[i] = d; m_clr[i] = d; m_valid[i] = 1'b1;
      end else begin
        m_clr[i] = '0;
      end
    end
    m_done = (dest == 3);
  endtask

  task automatic check_all();
    check("h_out0", bh.out0, m_hold[0]);  check("c_out0", bc.out0, m_clr[0]);
    check("h_out1", bh.out1, m_hold[1]);  check("c_out1", bc.out1, m_clr[1]);
    check("h_out2", bh.out2, m_hold[2]);  check("c_out2", bc.out2, m_clr[2]);
    check("h_out3", bh.out3, m_hold[3]);  check("c_out3", bc.out3, m_clr[3]);
    check("h_valid", bh.out_valid, m_valid); check("c_valid", bc.out_valid, m_valid);
    check("h_ch", bh.ch, 32'(m_next));    check("c_ch", bc.ch, 32'(m_next));
    check("h_locked", bh.locked, m_locked); check("c_locked", bc.locked, m_locked);
    check("h_done", bh.frame_done, m_done); check("c_done", bc.frame_done, m_done);
    check("h_err", bh.sync_err, m_err);   check("c_err", bc.sync_err, m_err);
  endtask

  // Called at posedge+1: drive, take one edge, then compare.
  task automatic cycle(input bit dv, input bit fs, input logic [WIDTH-1:0] d);
    bit man;
    int msel;
    man = 0; msel = 0;
`ifdef DEMUX_MANUAL_SEL_EN
    man = man_sel; msel = {30'd0, s1, s0};
`endif
    din = d; din_valid = dv; frame_sync = fs;
    @(posedge clk);
    model_step(dv, fs, d, man, msel);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    cycle(1, 1, 8'h11); cycle(1, 0, 8'h22); cycle(1, 0, 8'h33); cycle(1, 0, 8'h44);

    cycle(1, 0, 8'hA1); cycle(1, 0, 8'hA2); cycle(1, 1, 8'h55);
    cycle(0, 0, 8'h00);

    cycle(1, 1, 8'h01);
    for (int i = 2; i <= 9; i++) begin
      cycle(0, 0, 8'hEE);
      cycle(1, 0, 8'(i));
    end

    cycle(1, 1, 8'h61); cycle(1, 0, 8'h62);
    async_reset();

    cycle(1, 0, 8'hAA); cycle(1, 0, 8'hBB); cycle(1, 1, 8'hCC);
    cycle(0, 1, 8'h00); cycle(1, 0, 8'hD0);

`ifdef DEMUX_MANUAL_SEL_EN
    man_sel = 1'b1; s1 = 1'b1; s0 = 1'b0;
    cycle(1, 0, 8'h7E);
    cycle(1, 1, 8'h7F);
    man_sel = 1'b0;
    cycle(1, 0, 8'h80);
`endif

    for (int i = 0; i < 600; i++) begin
`ifdef DEMUX_MANUAL_SEL_EN
      man_sel = ($urandom_range(0, 5) == 0);
      s1 = 1'($urandom); s0 = 1'($urandom);
`endif
      if ($urandom_range(0, 99) == 0) async_reset();
      else cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
